// File: rtl/can_tx_frame_sequencer_pkg.sv
// can_tx_frame_sequencer_pkg: shared CAN TX states, field lengths and bus levels.
package can_tx_frame_sequencer_pkg;
   typedef enum logic [3:0] {
      ST_IDLE, ST_SOF, ST_ID_A, ST_SRR, ST_IDE, ST_ID_B, ST_RTR, ST_R1R0,
      ST_DLC, ST_DATA, ST_CRC, ST_CRCDEL, ST_ACK, ST_ACKDEL, ST_EOF, ST_IFS
   } state_e;
   localparam int ID_A_BITS = 11;
   localparam int ID_B_BITS = 18;
   localparam int DLC_BITS = 4;
   localparam int CRC_BITS = 15;
   localparam logic CAN_DOMINANT = 1'b1;
   localparam logic CAN_RECESSIVE = 1'b0;
   localparam logic [14:0] CRC_POLY = 15'h4599;
endpackage

// File: rtl/can_tx_frame_sequencer_crc.sv
// crc_step_machine: CAN CRC-15 accumulator, one bit per update pulse.
module crc_step_machine
   import can_tx_frame_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        next_bit,
   input  logic        clear_crc,
   input  logic        update_crc,
   output logic [14:0] crc
);
   logic [14:0] crc_q, crc_d;
   assign crc_d = clear_crc ? '0 :
                  update_crc ? ({crc_q[13:0], 1'b0} ^ ((next_bit ^ crc_q[14]) ? CRC_POLY : 15'd0)) :
                  crc_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) crc_q <= '0;
      else crc_q <= crc_d;
   end
   assign crc = crc_q;
endmodule

// File: rtl/can_tx_frame_sequencer.sv
// can_tx_frame_sequencer: walks one CAN 2.0A/B frame bit by bit into tx_pipeline,
// feeding the CRC and aborting on arbitration loss, bit error or missing ACK.
module can_tx_frame_sequencer
   import can_tx_frame_sequencer_pkg::*;
#(
   parameter int IFS_BITS = 3,
   parameter int EOF_BITS = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tx_request,
   input  logic [28:0] tx_id,
   input  logic        tx_extended,
   input  logic        tx_rtr,
   input  logic [3:0]  tx_dlc,
   input  logic [63:0] tx_data,
   input  logic        bus_idle,
   input  logic        bit_advance,
   input  logic        tx_line,
   input  logic        rx,
   input  logic        updated_sample,
   output logic        next_bit,
   output logic        stuff_bypass,
   output logic        tx_busy,
   output logic        tx_done,
   output logic        tx_arb_lost,
   output logic        tx_bit_error,
   output logic        tx_ack_error
);
   state_e      state_q, state_d, nxt;
   logic [6:0]  cnt_q, cnt_d, dbits_q, dbits_d, len;
   logic [28:0] id_q, id_d;
   logic [3:0]  dlc_q, dlc_d;
   logic [63:0] data_q, data_d;
   logic        ext_q, ext_d, rtr_q, rtr_d;
   logic        done_q, done_d, arb_q, arb_d, berr_q, berr_d, aerr_q, aerr_d;
   logic        clear_crc, update_crc, last, err;
   logic [14:0] crc;

   crc_step_machine u_crc (
      .clk        (clk),
      .rst        (rst),
      .next_bit   (next_bit),
      .clear_crc  (clear_crc),
      .update_crc (update_crc),
      .crc        (crc)
   );

   always_comb begin
      len = state_q == ST_ID_A ? 7'(ID_A_BITS) :
            state_q == ST_ID_B ? 7'(ID_B_BITS) :
            state_q == ST_R1R0 ? 7'd2 :
            state_q == ST_DLC  ? 7'(DLC_BITS) :
            state_q == ST_DATA ? dbits_q :
            state_q == ST_CRC  ? 7'(CRC_BITS) :
            state_q == ST_EOF  ? 7'(EOF_BITS) :
            state_q == ST_IFS  ? 7'(IFS_BITS) : 7'd1;
   end

   assign last = cnt_q == len - 7'd1;
   // Fields follow enum order; IFS + 1 wraps back to IDLE.
   assign nxt = (state_q == ST_ID_A && !ext_q) ? ST_RTR :
                (state_q == ST_DLC && dbits_q == 7'd0) ? ST_CRC :
                state_e'(state_q + 4'd1);

   assign arb_d  = updated_sample && state_q inside {[ST_ID_A:ST_RTR]} &&
                   tx_line == CAN_RECESSIVE && rx == CAN_DOMINANT;
   assign aerr_d = updated_sample && state_q == ST_ACK && rx == CAN_RECESSIVE;
   assign berr_d = updated_sample && rx != tx_line &&
                   state_q inside {ST_SOF, ST_R1R0, ST_DLC, ST_DATA, ST_CRC, ST_CRCDEL, ST_ACKDEL, ST_EOF};
   assign err        = arb_d || aerr_d || berr_d;
   assign clear_crc  = state_q == ST_IDLE && tx_request && bus_idle;
   assign update_crc = bit_advance && !err && state_q inside {[ST_SOF:ST_DATA]};
   assign done_d     = bit_advance && !err && state_q == ST_IFS && last;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      id_d    = id_q;
      ext_d   = ext_q;
      rtr_d   = rtr_q;
      dlc_d   = dlc_q;
      dbits_d = dbits_q;
      data_d  = data_q;
      if (clear_crc) begin
         state_d = ST_SOF;
         cnt_d   = '0;
         id_d    = tx_id;
         ext_d   = tx_extended;
         rtr_d   = tx_rtr;
         dlc_d   = tx_dlc;
         data_d  = tx_data;
         dbits_d = tx_rtr ? 7'd0 : tx_dlc[3] ? 7'd64 : {1'b0, tx_dlc[2:0], 3'b000};
      end else if (err) begin
         state_d = ST_IDLE;
      end else if (bit_advance && state_q != ST_IDLE) begin
         state_d = last ? nxt : state_q;
         cnt_d   = last ? 7'd0 : cnt_q + 7'd1;
         if (state_q inside {ST_ID_A, ST_ID_B}) id_d = {id_q[27:0], 1'b0};
         if (state_q == ST_DLC) dlc_d = {dlc_q[2:0], 1'b0};
         if (state_q == ST_DATA) data_d = {data_q[62:0], 1'b0};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         id_q    <= '0;
         ext_q   <= 1'b0;
         rtr_q   <= 1'b0;
         dlc_q   <= '0;
         dbits_q <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
         arb_q   <= 1'b0;
         berr_q  <= 1'b0;
         aerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         id_q    <= id_d;
         ext_q   <= ext_d;
         rtr_q   <= rtr_d;
         dlc_q   <= dlc_d;
         dbits_q <= dbits_d;
         data_q  <= data_d;
         done_q  <= done_d;
         arb_q   <= arb_d;
         berr_q  <= berr_d;
         aerr_q  <= aerr_d;
      end
   end

   // CRC stays frozen during its field, so it is read out by index, MSB first.
   always_comb begin
      next_bit = state_q inside {ST_SOF, ST_R1R0} ? CAN_DOMINANT :
                 state_q inside {ST_ID_A, ST_ID_B} ? id_q[28] :
                 state_q == ST_RTR  ? (rtr_q ? CAN_RECESSIVE : CAN_DOMINANT) :
                 state_q == ST_DLC  ? dlc_q[3] :
                 state_q == ST_DATA ? data_q[63] :
                 state_q == ST_CRC  ? crc[4'd14 - cnt_q[3:0]] : CAN_RECESSIVE;
   end

   assign stuff_bypass = !(state_q inside {[ST_SOF:ST_CRC]});
   assign tx_busy      = state_q != ST_IDLE;
   assign tx_done      = done_q;
   assign tx_arb_lost  = arb_q;
   assign tx_bit_error = berr_q;
   assign tx_ack_error = aerr_q;
endmodule

// File: tb/tb_can_tx_frame_sequencer.sv
// tb_can_tx_frame_sequencer: drives frames through an ideal bus and checks the
// emitted bit sequence against a field-by-field frame model.
module tb_can_tx_frame_sequencer;
   logic        clk = 1'b0, rst = 1'b1, tx_request = 1'b0, tx_extended = 1'b0, tx_rtr = 1'b0;
   logic [28:0] tx_id = '0;
   logic [3:0]  tx_dlc = '0;
   logic [63:0] tx_data = '0;
   logic        bus_idle = 1'b1, bit_advance = 1'b0, tx_line = 1'b0, rx = 1'b0, updated_sample = 1'b0;
   logic        next_bit, stuff_bypass, tx_busy, tx_done, tx_arb_lost, tx_bit_error, tx_ack_error;

   int checks = 0, errors = 0;
   int n_done = 0, n_arb = 0, n_berr = 0, n_aerr = 0;
   int n_crc;
   bit obs_bits[$], obs_sb[$], exp_bits[$];

   always #5 clk = ~clk;

   can_tx_frame_sequencer dut (
      .clk(clk), .rst(rst), .tx_request(tx_request), .tx_id(tx_id), .tx_extended(tx_extended),
      .tx_rtr(tx_rtr), .tx_dlc(tx_dlc), .tx_data(tx_data), .bus_idle(bus_idle),
      .bit_advance(bit_advance), .tx_line(tx_line), .rx(rx), .updated_sample(updated_sample),
      .next_bit(next_bit), .stuff_bypass(stuff_bypass), .tx_busy(tx_busy), .tx_done(tx_done),
      .tx_arb_lost(tx_arb_lost), .tx_bit_error(tx_bit_error), .tx_ack_error(tx_ack_error)
   );

   always @(negedge clk) begin
      if (tx_done) n_done++;
      if (tx_arb_lost) n_arb++;
      if (tx_bit_error) n_berr++;
      if (tx_ack_error) n_aerr++;
   end

   // Reference frame: fields appended in order, CRC-15 over SOF..DATA, then fixed tail.
   function automatic void build_frame(input logic [28:0] id, input bit ext, input bit rtr,
                                       input logic [3:0] dlc, input logic [63:0] data);
      logic [14:0] c = '0;
      int nb;
      exp_bits.delete();
      exp_bits.push_back(1'b1);
      for (int i = 28; i >= 18; i--) exp_bits.push_back(id[i]);
      if (ext) begin
         exp_bits.push_back(1'b0);
         exp_bits.push_back(1'b0);
         for (int i = 17; i >= 0; i--) exp_bits.push_back(id[i]);
      end
      exp_bits.push_back(!rtr);
      exp_bits.push_back(1'b1);
      exp_bits.push_back(1'b1);
      for (int i = 3; i >= 0; i--) exp_bits.push_back(dlc[i]);
      nb = rtr ? 0 : (dlc > 8 ? 64 : int'(dlc) * 8);
      for (int i = 0; i < nb; i++) exp_bits.push_back(data[63-i]);
      n_crc = exp_bits.size();
      foreach (exp_bits[i]) begin
         bit f;
         f = exp_bits[i] ^ c[14];
         c = {c[13:0], 1'b0};
         if (f) c = c ^ 15'h4599;
      end
      for (int i = 14; i >= 0; i--) exp_bits.push_back(c[i]);
      repeat (3 + 7 + 3) exp_bits.push_back(1'b0);
      tx_id = id; tx_extended = ext; tx_rtr = rtr; tx_dlc = dlc; tx_data = data;
   endfunction

   function automatic int bit_mismatches();
      int m = 0;
      for (int i = 0; i < obs_bits.size() && i < exp_bits.size(); i++)
         if (obs_bits[i] != exp_bits[i]) m++;
      return m;
   endfunction

   function automatic int sb_mismatches();
      int m = 0;
      foreach (obs_sb[i]) if (obs_sb[i] != (i >= n_crc + 15)) m++;
      return m;
   endfunction

   // Ideal tx_pipeline/bus: echo next_bit, sample it, then consume it.
   task automatic drive_frame(input int force_idx, input bit force_rx, input bit ack_dom, input int max_bits);
      int ack_idx = n_crc + 16;
      obs_bits.delete();
      obs_sb.delete();
      tx_request = 1'b1;
      bus_idle = 1'b1;
      @(negedge clk);
      tx_request = 1'b0;
      for (int i = 0; i < max_bits && tx_busy; i++) begin
         obs_bits.push_back(next_bit);
         obs_sb.push_back(stuff_bypass);
         tx_line = next_bit;
         @(negedge clk);
         updated_sample = 1'b1;
         rx = (i == force_idx) ? force_rx : (i == ack_idx) ? ack_dom : tx_line;
         @(negedge clk);
         updated_sample = 1'b0;
         bit_advance = 1'b1;
         @(negedge clk);
         bit_advance = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if ({next_bit, stuff_bypass, tx_busy} !== 3'b010) begin
         errors++;
         $display("FAIL reset_outputs: got nb/sb/busy=%b required 010", {next_bit, stuff_bypass, tx_busy});
      end
      checks++;
      if ({tx_done, tx_arb_lost, tx_bit_error, tx_ack_error} !== 4'b0) begin
         errors++;
         $display("FAIL reset_status: got %b required 0000", {tx_done, tx_arb_lost, tx_bit_error, tx_ack_error});
      end
   endtask

   task automatic test_good_frame(input string name, input logic [28:0] id, input bit ext, input bit rtr,
                                  input logic [3:0] dlc, input logic [63:0] data, input int req_len);
      int d0 = n_done, e0 = n_arb + n_berr + n_aerr;
      build_frame(id, ext, rtr, dlc, data);
      drive_frame(-1, 1'b0, 1'b1, 200);
      checks++;
      if (obs_bits.size() != req_len) begin
         errors++;
         $display("FAIL %s_length: got %0d bits required %0d", name, obs_bits.size(), req_len);
      end
      checks++;
      if (bit_mismatches() != 0) begin
         errors++;
         $display("FAIL %s_bits: got %0d mismatching bits required 0", name, bit_mismatches());
      end
      checks++;
      if (sb_mismatches() != 0) begin
         errors++;
         $display("FAIL %s_stuff_bypass: got %0d mismatching bits required 0", name, sb_mismatches());
      end
      checks++;
      if (n_done - d0 != 1 || n_arb + n_berr + n_aerr - e0 != 0) begin
         errors++;
         $display("FAIL %s_status: got done=%0d errs=%0d required done=1 errs=0", name, n_done - d0, n_arb + n_berr + n_aerr - e0);
      end
   endtask

   task automatic test_base_dlc0();
      test_good_frame("base_dlc0", {11'b01100110011, 18'd0}, 1'b0, 1'b0, 4'd0, 64'd0, 44 + 3);
   endtask

   task automatic test_base_dlc8();
      test_good_frame("base_dlc8", {11'b10001010101, 18'd0}, 1'b0, 1'b0, 4'd8, 64'hd3359da81bd963e5, 108 + 3);
   endtask

   task automatic test_extended();
      test_good_frame("extended", {11'b01100110011, 18'b100010101010101010}, 1'b1, 1'b0, 4'd8,
                      64'h0123456789abcdef, 128 + 3);
      checks++;
      if (obs_bits.size() < 14 || obs_bits[12] != 1'b0 || obs_bits[13] != 1'b0) begin
         errors++;
         $display("FAIL extended_srr_ide: got %0d%0d required 00", obs_bits.size() > 12 ? obs_bits[12] : 1'b1,
                  obs_bits.size() > 13 ? obs_bits[13] : 1'b1);
      end
   endtask

   task automatic test_random_frames();
      for (int k = 0; k < 8; k++) begin
         bit ext = 1'($urandom);
         bit rtr = ($urandom_range(0, 3) == 0);
         logic [3:0] dlc = 4'($urandom);
         int nb = rtr ? 0 : (dlc > 8 ? 64 : int'(dlc) * 8);
         test_good_frame($sformatf("random%0d", k), 29'($urandom), ext, rtr, dlc, {$urandom, $urandom},
                         (ext ? 39 : 19) + nb + 25 + 3);
      end
   endtask

   task automatic test_arb_lost();
      int a0 = n_arb, o0 = n_done + n_berr + n_aerr;
      build_frame({11'b10001010101, 18'd0}, 1'b0, 1'b0, 4'd1, 64'hff00000000000000);
      drive_frame(3, 1'b1, 1'b1, 200);
      checks++;
      if (obs_bits.size() != 4) begin
         errors++;
         $display("FAIL arb_stop_point: got %0d bits required 4", obs_bits.size());
      end
      checks++;
      if (n_arb - a0 != 1 || n_done + n_berr + n_aerr - o0 != 0) begin
         errors++;
         $display("FAIL arb_status: got arb=%0d others=%0d required arb=1 others=0", n_arb - a0, n_done + n_berr + n_aerr - o0);
      end
      checks++;
      if ({tx_busy, stuff_bypass, next_bit} !== 3'b010) begin
         errors++;
         $display("FAIL arb_idle: got busy/sb/nb=%b required 010", {tx_busy, stuff_bypass, next_bit});
      end
   endtask

   task automatic test_ack_error();
      int a0 = n_aerr, o0 = n_done + n_berr + n_arb;
      build_frame({11'b00101100111, 18'd0}, 1'b0, 1'b0, 4'd2, {$urandom, $urandom});
      drive_frame(-1, 1'b0, 1'b0, 200);
      checks++;
      if (obs_bits.size() != n_crc + 17 || n_aerr - a0 != 1 || n_done + n_berr + n_arb - o0 != 0) begin
         errors++;
         $display("FAIL ack_error: got bits=%0d ack=%0d others=%0d required bits=%0d ack=1 others=0",
                  obs_bits.size(), n_aerr - a0, n_done + n_berr + n_arb - o0, n_crc + 17);
      end
   endtask

   task automatic test_bit_error();
      int b0 = n_berr, o0 = n_done + n_aerr + n_arb;
      build_frame({11'b11100001111, 18'd0}, 1'b0, 1'b0, 4'd3, {$urandom, $urandom});
      drive_frame(n_crc + 15, 1'b1, 1'b1, 200);
      checks++;
      if (obs_bits.size() != n_crc + 16 || n_berr - b0 != 1 || n_done + n_aerr + n_arb - o0 != 0) begin
         errors++;
         $display("FAIL crcdel_bit_error: got bits=%0d berr=%0d others=%0d required bits=%0d berr=1 others=0",
                  obs_bits.size(), n_berr - b0, n_done + n_aerr + n_arb - o0, n_crc + 16);
      end
      checks++;
      if ({tx_busy, stuff_bypass} !== 2'b01) begin
         errors++;
         $display("FAIL bit_error_idle: got busy/sb=%b required 01", {tx_busy, stuff_bypass});
      end
   endtask

   task automatic test_holdoff();
      bit seen = 1'b0;
      build_frame({11'b01010101010, 18'd0}, 1'b0, 1'b0, 4'd0, 64'd0);
      bus_idle = 1'b0;
      tx_request = 1'b1;
      repeat (50) @(negedge clk) if (tx_busy) seen = 1'b1;
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL holdoff_busy: got busy=1 while bus not idle required 0");
      end
      bus_idle = 1'b1;
      @(negedge clk);
      tx_request = 1'b0;
      checks++;
      if ({tx_busy, next_bit, stuff_bypass} !== 3'b110) begin
         errors++;
         $display("FAIL holdoff_start: got busy/nb/sb=%b required 110", {tx_busy, next_bit, stuff_bypass});
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset_mid();
      int s0 = n_done + n_arb + n_berr + n_aerr;
      build_frame({11'b10001010101, 18'd0}, 1'b0, 1'b0, 4'd8, 64'hd3359da81bd963e5);
      drive_frame(-1, 1'b0, 1'b1, 30);
      checks++;
      if (tx_busy !== 1'b1 || stuff_bypass !== 1'b0 || bit_mismatches() != 0) begin
         errors++;
         $display("FAIL mid_data_state: got busy=%b sb=%b mism=%0d required busy=1 sb=0 mism=0",
                  tx_busy, stuff_bypass, bit_mismatches());
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({tx_busy, next_bit, stuff_bypass, tx_done, tx_arb_lost, tx_bit_error, tx_ack_error} !== 7'b0010000) begin
         errors++;
         $display("FAIL reset_mid_data: got %b required 0010000",
                  {tx_busy, next_bit, stuff_bypass, tx_done, tx_arb_lost, tx_bit_error, tx_ack_error});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (n_done + n_arb + n_berr + n_aerr - s0 != 0) begin
         errors++;
         $display("FAIL reset_no_status: got %0d pulses required 0", n_done + n_arb + n_berr + n_aerr - s0);
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b0;
      @(negedge clk);
      test_base_dlc0();
      test_base_dlc8();
      test_extended();
      test_random_frames();
      test_arb_lost();
      test_ack_error();
      test_bit_error();
      test_holdoff();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
